// File: rtl/parity_check_fifo_if.sv
// Handshake bundle for parity_check_fifo:
// upstream words, FIFO head, stats.
interface parity_check_fifo_if #(
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic [2:0]       data_i;
  logic             parity_i;
  logic             ready_o;
  logic             valid_o;
  logic [2:0]       data_o;
  logic             err_o;
  logic             ready_i;
  logic             clear_i;
  logic [CNT_W-1:0] err_cnt_o;
  logic             alarm_o;

  modport master (
    output valid_i, data_i, parity_i,
    output ready_i, clear_i,
    input  ready_o, valid_o, data_o,
    input  err_o, err_cnt_o, alarm_o
  );

  modport slave (
    input  valid_i, data_i, parity_i,
    input  ready_i, clear_i,
    output ready_o, valid_o, data_o,
    output err_o, err_cnt_o, alarm_o
  );
endinterface

// File: rtl/parity_check_fifo.sv
// Odd-parity checker feeding a FWFT FIFO,
// with error stats and consecutive-error lockout.
module parity_check_fifo #(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 3
) (
  input logic clk_i,
  input logic rst_i,
  parity_check_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN, LOCK} state_t;

  state_t           state;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [3:0]       mem [DEPTH];
  logic [3:0]       last;
  logic [3:0]       head;
  logic [7:0]       consec;
  logic [CNT_W-1:0] err_cnt;
  logic             alarm;
  logic             full;
  logic             empty;
  logic             acc;
  logic             push;
  logic             pop;
  logic             err;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign err   = bus.parity_i != ^bus.data_i;

  assign bus.ready_o = !rst_i && (state == LOCK || !full);

  assign acc  = bus.valid_i && bus.ready_o;
  assign push = acc && state == RUN;
  assign pop  = !empty && bus.ready_i;

  // Empty FIFO keeps showing the last popped word.
  assign head = empty ? last : mem[rptr[AW-1:0]];

  assign bus.valid_o   = !empty;
  assign bus.data_o    = head[2:0];
  assign bus.err_o     = head[3];
  assign bus.err_cnt_o = err_cnt;
  assign bus.alarm_o   = alarm;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      last <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= {err, bus.data_i};
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        last <= head;
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RUN;
      consec  <= '0;
      err_cnt <= '0;
      alarm   <= 1'b0;
    end else if (bus.clear_i) begin
      state   <= RUN;
      consec  <= '0;
      err_cnt <= '0;
      alarm   <= 1'b0;
    end else if (push && err) begin
      consec <= consec + 8'd1;
      if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      if (consec + 8'd1 == 8'(ALARM_THRESH)) begin
        state <= LOCK;
        alarm <= 1'b1;
      end
    end else if (push) begin
      consec <= '0;
    end
  end
endmodule

// File: tb/tb_parity_check_fifo.sv
// Directed bench for parity_check_fifo:
// main instance plus a 2-bit counter instance.
module tb_parity_check_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  parity_check_fifo_if #(.CNT_W(8)) a ();
  parity_check_fifo_if #(.CNT_W(2)) b ();

  parity_check_fifo #(
    .DEPTH(4), .CNT_W(8), .ALARM_THRESH(3)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(a)
  );

  parity_check_fifo #(
    .DEPTH(4), .CNT_W(2), .ALARM_THRESH(3)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .bus(b)
  );

  always #5 clk = ~clk;

  // {err, parity, data}
  logic [4:0] strm [6] = '{
    5'b0_1_001, 5'b0_0_011, 5'b0_1_111,
    5'b0_0_000, 5'b1_0_010, 5'b0_0_101
  };
  logic [4:0] lock [3] = '{
    5'b1_0_100, 5'b1_1_110, 5'b1_0_001
  };
  logic [4:0] fpar = 5'b01011;
  int         sat_exp [5] = '{1, 2, 3, 3, 3};
  logic [4:0] v;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] d,
                     input logic p);
    a.valid_i  = 1'b1;
    a.data_i   = d;
    a.parity_i = p;
    tick();
  endtask

  initial begin
    a.valid_i = 0; a.data_i = 0; a.parity_i = 0;
    a.ready_i = 1; a.clear_i = 0;
    b.valid_i = 0; b.data_i = 0; b.parity_i = 0;
    b.ready_i = 1; b.clear_i = 0;

    #1;
    chk("rst_valid", a.valid_o, 0);
    chk("rst_ready", a.ready_o, 0);
    chk("rst_data", a.data_o, 0);
    chk("rst_err", a.err_o, 0);
    chk("rst_cnt", a.err_cnt_o, 0);
    chk("rst_alarm", a.alarm_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel_ready", a.ready_o, 1);

    for (int i = 0; i < 6; i++) begin
      v = strm[i];
      put(v[2:0], v[3]);
      chk("st_valid", a.valid_o, 1);
      chk("st_data", a.data_o, v[2:0]);
      chk("st_err", a.err_o, v[4]);
      if (i == 3) chk("st_cnt0", a.err_cnt_o, 0);
    end
    a.valid_i = 0;
    tick();
    chk("st_empty", a.valid_o, 0);
    chk("st_hold", a.data_o, 3'b101);
    chk("st_cnt1", a.err_cnt_o, 1);
    chk("st_alarm", a.alarm_o, 0);

    a.clear_i = 1;
    tick();
    a.clear_i = 0;
    chk("clr_cnt", a.err_cnt_o, 0);

    for (int i = 0; i < 3; i++) begin
      v = lock[i];
      put(v[2:0], v[3]);
      chk("lk_data", a.data_o, v[2:0]);
      chk("lk_err", a.err_o, v[4]);
      chk("lk_alarm", a.alarm_o, i == 2);
    end
    chk("lk_cnt", a.err_cnt_o, 3);
    a.data_i = 3'b011;
    a.parity_i = 0;
    chk("lk_rdy", a.ready_o, 1);
    tick();
    a.valid_i = 0;
    chk("lk_drop", a.valid_o, 0);
    chk("lk_cnt2", a.err_cnt_o, 3);
    chk("lk_alarm2", a.alarm_o, 1);
    chk("lk_rdy2", a.ready_o, 1);

    a.clear_i = 1;
    tick();
    a.clear_i = 0;
    chk("ul_alarm", a.alarm_o, 0);
    chk("ul_cnt", a.err_cnt_o, 0);
    put(3'b011, 1'b0);
    a.valid_i = 0;
    chk("ul_valid", a.valid_o, 1);
    chk("ul_data", a.data_o, 3'b011);

    a.clear_i = 1;
    put(3'b010, 1'b0);
    a.clear_i = 0;
    a.valid_i = 0;
    chk("cw_valid", a.valid_o, 1);
    chk("cw_err", a.err_o, 1);
    chk("cw_cnt", a.err_cnt_o, 0);
    chk("cw_alarm", a.alarm_o, 0);
    put(3'b100, 1'b0);
    put(3'b110, 1'b1);
    a.valid_i = 0;
    chk("cw_noalarm", a.alarm_o, 0);
    chk("cw_cnt2", a.err_cnt_o, 2);
    a.clear_i = 1;
    tick();
    a.clear_i = 0;

    a.ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      a.valid_i  = 1;
      a.data_i   = 3'(i + 1);
      a.parity_i = fpar[i];
      chk("fl_rdy", a.ready_o, 1);
      tick();
    end
    chk("fl_full", a.ready_o, 0);
    a.data_i   = 3'd5;
    a.parity_i = fpar[4];
    tick();
    chk("fl_held", a.ready_o, 0);
    a.ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      chk("po_valid", a.valid_o, 1);
      chk("po_data", a.data_o, i + 1);
      chk("po_err", a.err_o, 0);
      if (i == 0) chk("po_nopush", a.ready_o, 0);
      if (i == 1) chk("po_rdy", a.ready_o, 1);
      tick();
      if (i == 1) a.valid_i = 0;
    end
    chk("po_empty", a.valid_o, 0);

    for (int k = 0; k < 5; k++) begin
      b.valid_i  = 1;
      b.data_i   = 3'b010;
      b.parity_i = 0;
      tick();
      b.data_i = 3'b011;
      tick();
      chk("sat_cnt", b.err_cnt_o, sat_exp[k]);
    end
    b.valid_i = 0;
    chk("sat_alarm", b.alarm_o, 0);

    a.ready_i = 0;
    put(3'b010, 1'b0);
    put(3'b001, 1'b1);
    a.valid_i = 0;
    chk("mr_cnt", a.err_cnt_o, 1);
    chk("mr_valid", a.valid_o, 1);
    #3 rst = 1'b1;
    #1;
    chk("mr_valid0", a.valid_o, 0);
    chk("mr_ready0", a.ready_o, 0);
    chk("mr_cnt0", a.err_cnt_o, 0);
    chk("mr_data0", a.data_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mr_rdy", a.ready_o, 1);
    chk("mr_cnt", a.err_cnt_o, 0);
    a.ready_i = 1;
    tick();
    chk("mr_flush", a.valid_o, 0);
    chk("mr_bcnt", b.err_cnt_o, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/parity_check_fifo.md
# parity_check_fifo

Downstream consumer of the 3-bit odd-parity generator stage. Accepts a valid/ready stream of 3-bit words, each paired with the parity bit produced for it, and recomputes parity to flag corrupted words. Checked words are buffered in a small first-word-fall-through FIFO for the next stage. Error statistics are tracked, and a lockout state machine stops intake after a run of consecutive parity errors.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- CNT_W, 8: width of the saturating error counter.
- ALARM_THRESH, 3: consecutive accepted erroneous words that trigger lockout; 1..255.

- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_i  input  1  reset; asynchronous and active-high.
- valid_i  input  1  upstream word valid.
- data_i  input  3  upstream data word.
- parity_i  input  1  parity bit supplied by the generator stage for data_i.
- ready_o  output  1  block can accept a word this cycle.
- valid_o  output  1  FIFO head valid.
- data_o  output  3  FIFO head data.
- err_o  output  1  FIFO head parity-error flag.
- ready_i  input  1  downstream accepts the head word.
- clear_i  input  1  synchronous pulse that clears the statistics and exits lockout.
- err_cnt_o  output  CNT_W  total accepted erroneous words, saturating.
- alarm_o  output  1  high while in the LOCK state.

## Operation
- **Parity rule:** expected = XOR of data_i[2:0], so it is 1 for an odd count of ones. Examples: 001→1, 011→0, 111→1.
  - err = (parity_i != expected).
- **Accept:** a word is accepted when valid_i && ready_o.
- **States:** RUN and LOCK.
  - RUN: ready_o = !full. Accepted words are pushed as {err, data}.
  - LOCK: ready_o = 1. Accepted words are dropped. They are not pushed, not counted and do not affect the consecutive-error count.
- **Consecutive-error counter (internal, 8-bit):**
  - Accepted word with err=1 in RUN: increment.
  - Accepted word with err=0 in RUN: reset to 0.
  - When an increment makes it equal ALARM_THRESH, the next state is LOCK.
  - The triggering word is still pushed with err=1 and counted.
- **err_cnt_o:** increments on each accepted erroneous word in RUN and saturates at 2^CNT_W−1. It does not wrap.
- **clear_i:**
  - Zeroes err_cnt_o and the consecutive counter. In LOCK, the next state is RUN.
  - When clear_i coincides with an accepted erroneous word in RUN, the clear wins: counters go to 0 and the state stays RUN, but the word is still pushed.
  - clear_i has no effect on FIFO contents.
- **FIFO:**
  - First-word-fall-through. valid_o = !empty; data_o and err_o show the head entry.
  - Pop when valid_o && ready_i.
  - Read and write pointers have one extra wrap bit. Full = MSBs differ and the lower bits are equal.
- **Full:** ready_o is derived from full only, with no pass-through. A full FIFO refuses a push even if a pop happens in the same cycle.
- **Empty:** nothing is popped. The head is undefined but data_o and err_o must hold their last value rather than X.
- **Simultaneous push and pop when not full and not empty:** occupancy is unchanged.
- **LOCK draining:** the FIFO keeps draining normally while in LOCK.

## Timing
- **Reset values (asynchronous, take effect immediately):**
  - State RUN, FIFO empty, all counters 0.
  - valid_o=0, data_o=0, err_o=0, err_cnt_o=0, alarm_o=0.
  - ready_o=0 while rst_i is high; ready_o=1 in the first cycle after release.
- **Latency:** a word accepted at edge N appears on valid_o/data_o/err_o after edge N, i.e. 1 cycle.
- **Throughput:** 1 word per cycle when not full.
- **alarm_o:** rises in the cycle after the edge that accepts the ALARM_THRESH-th consecutive erroneous word. It falls in the cycle after the edge sampling clear_i.
- **err_cnt_o:** registered; it reflects an accepted word one cycle after acceptance.
- **Reset mid-operation:** flushes the FIFO and counters immediately. No buffered word is presented after reset.

## Test plan
- **Clean stream:** reset, ready_i=1; send 001/p1, 011/p0, 111/p1, 000/p0 back-to-back.
  - Required: each word appears 1 cycle later with err_o=0.
  - err_cnt_o=0, alarm_o=0.
- **Error flag:** send 010/p0, then 101/p0.
  - Required: err_o=1 for the first word and err_o=0 for the second.
  - err_cnt_o=1; consecutive counter returns to 0.
- **Lockout:** send three words with wrong parity (100/p0, 110/p1, 001/p0), then 011/p0.
  - Required: alarm_o=1 from the cycle after the third error; err_cnt_o=3.
  - The fourth word is dropped: only 3 entries are output and ready_o stays 1.
  - Pulse clear_i. Required: alarm_o=0 and err_cnt_o=0 next cycle, and the next valid word is accepted.
- **Full/backpressure:** ready_i=0; push 5 valid words.
  - Required: ready_o=0 after 4 pushes; the 5th is held.
  - Then ready_i=1 with valid_i=1 held. Required: pop order 1..5 and no push accepted in the cycle the FIFO is full.
- **Saturation and reset:** with CNT_W=2, send 5 isolated erroneous words separated by good words.
  - Required: err_cnt_o sticks at 3.
  - Assert rst_i mid-stream with 2 entries buffered. Required: valid_o=0 immediately; after release, ready_o=1 and err_cnt_o=0.
